// File: rtl/timing_pkg.sv
// rtl/timing_pkg.sv - command encodings, DDR4-2400 timing constants and constraint lookup
package timing_pkg;

    localparam logic [2:0] CMD_NOP  = 3'd0;
    localparam logic [2:0] CMD_PRE  = 3'd1;
    localparam logic [2:0] CMD_ACT  = 3'd2;
    localparam logic [2:0] CMD_RD   = 3'd3;
    localparam logic [2:0] CMD_WR   = 3'd4;
    localparam logic [2:0] CMD_RDA  = 3'd5;
    localparam logic [2:0] CMD_WRA  = 3'd6;
    localparam logic [2:0] CMD_PREA = 3'd7;

    // Counter slots per bank entry
    localparam int CI_PRE = 0;
    localparam int CI_ACT = 1;
    localparam int CI_RD  = 2;
    localparam int CI_WR  = 3;
    localparam int NUM_CI = 4;

    localparam int unsigned T_RCD   = 16;
    localparam int unsigned T_RP    = 16;
    localparam int unsigned T_RAS   = 39;
    localparam int unsigned T_RC    = 55;
    localparam int unsigned T_RRD_S = 4;
    localparam int unsigned T_RRD_L = 6;
    localparam int unsigned T_CCD_S = 4;
    localparam int unsigned T_CCD_L = 6;
    localparam int unsigned T_RTP   = 9;
    localparam int unsigned T_WRPRE = 34;
    localparam int unsigned T_WTR_S = 17;
    localparam int unsigned T_WTR_L = 23;
    localparam int unsigned T_RTW   = 8;
    localparam int unsigned T_FAW   = 26;

    localparam int FAW_SLOTS = 4;

    typedef struct packed {
        int unsigned pre;
        int unsigned act;
        int unsigned rd;
        int unsigned wr;
    } cons_t;

    // Cycles a command imposes on a neighbouring bank; same_bg/same_bnk imply same_rnk.
    function automatic cons_t cmd_cons(input logic [2:0] cmd, input logic same_bnk,
                                       input logic same_bg, input logic same_rnk);
        cons_t c;
        c = '0;
        if (same_rnk) begin
            case (cmd)
                CMD_ACT: begin
                    if (same_bnk) begin
                        c.rd  = T_RCD;
                        c.wr  = T_RCD;
                        c.pre = T_RAS;
                        c.act = T_RC;
                    end else begin
                        c.act = same_bg ? T_RRD_L : T_RRD_S;
                    end
                end
                CMD_PRE:  if (same_bnk) c.act = T_RP;
                CMD_PREA: c.act = T_RP;
                CMD_RD, CMD_RDA: begin
                    if (same_bnk) c.pre = T_RTP;
                    c.rd = same_bg ? T_CCD_L : T_CCD_S;
                    c.wr = T_RTW;
                    if (same_bnk && cmd == CMD_RDA) c.act = T_RTP + T_RP;
                end
                CMD_WR, CMD_WRA: begin
                    if (same_bnk) c.pre = T_WRPRE;
                    c.wr = same_bg ? T_CCD_L : T_CCD_S;
                    c.rd = same_bg ? T_WTR_L : T_WTR_S;
                    if (same_bnk && cmd == CMD_WRA) c.act = T_WRPRE + T_RP;
                end
                default: c = '0;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/act_window.sv
// rtl/act_window.sv - per-rank four-activate window (tFAW) timers
module act_window
    import timing_pkg::*;
#(
    parameter int TW = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic act_fire,
    output logic slot_free
);

    logic [TW-1:0] tmr_q [FAW_SLOTS];
    logic [TW-1:0] tmr_d [FAW_SLOTS];

    // A new ACT claims the lowest idle timer; the load wins over the decrement.
    always_comb begin
        logic placed;
        placed    = 1'b0;
        slot_free = 1'b0;
        for (int i = 0; i < FAW_SLOTS; i++) begin
            tmr_d[i] = (tmr_q[i] != '0) ? tmr_q[i] - TW'(1) : '0;
            if (tmr_q[i] == '0) begin
                slot_free = 1'b1;
                if (act_fire && !placed) begin
                    tmr_d[i] = TW'(T_FAW - 1);
                    placed   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FAW_SLOTS; i++) tmr_q[i] <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

endmodule

// File: rtl/cmd_timing_gate.sv
// rtl/cmd_timing_gate.sv - per-bank timing legality gate and issue register for DRAM commands
module cmd_timing_gate
    import timing_pkg::*;
#(
    parameter int NUM_RNK               = 1,
    parameter int NUM_BG                = 4,
    parameter int NUM_BNK               = 4,
    parameter int RNK_SEL_WIDTH         = 1,
    parameter int BG_SEL_WIDTH          = 2,
    parameter int BNK_SEL_WIDTH         = 2,
    parameter int CMD_TYPE_WIDTH        = 3,
    parameter int TIME_CONSTRAINT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [CMD_TYPE_WIDTH-1:0] req_cmd,
    input  logic [RNK_SEL_WIDTH-1:0]  req_rnk,
    input  logic [BG_SEL_WIDTH-1:0]   req_bg,
    input  logic [BNK_SEL_WIDTH-1:0]  req_bnk,
    output logic                      req_ready,
    output logic                      issue_valid,
    output logic [CMD_TYPE_WIDTH-1:0] issue_cmd,
    output logic [RNK_SEL_WIDTH-1:0]  issue_rnk,
    output logic [BG_SEL_WIDTH-1:0]   issue_bg,
    output logic [BNK_SEL_WIDTH-1:0]  issue_bnk
);

    localparam int TW          = TIME_CONSTRAINT_WIDTH;
    localparam int BNK_PER_RNK = NUM_BG * NUM_BNK;
    localparam int NUM_ENT     = NUM_RNK * BNK_PER_RNK;

    if ((T_RC > (1 << TW) - 1) || (T_WRPRE + T_RP > (1 << TW) - 1)) begin : g_width_chk
        $error("TIME_CONSTRAINT_WIDTH too narrow for tRC or tWRPRE+tRP");
    end

    logic [TW-1:0] cnt_q [NUM_ENT][NUM_CI];
    logic [TW-1:0] cnt_d [NUM_ENT][NUM_CI];

    logic [NUM_RNK-1:0] faw_free;
    logic [NUM_RNK-1:0] act_fire;
    logic [2:0]         cmd;
    logic               in_range;
    logic               legal;
    logic               faw_ok;
    logic               accept;
    int                 rnk_i, bg_i, bnk_i, tgt_i;
    logic [TW-1:0]      sel_pre, sel_act, sel_rd, sel_wr;

    logic                      issue_valid_q, issue_valid_d;
    logic [CMD_TYPE_WIDTH-1:0] issue_cmd_q, issue_cmd_d;
    logic [RNK_SEL_WIDTH-1:0]  issue_rnk_q, issue_rnk_d;
    logic [BG_SEL_WIDTH-1:0]   issue_bg_q, issue_bg_d;
    logic [BNK_SEL_WIDTH-1:0]  issue_bnk_q, issue_bnk_d;

    function automatic logic [TW-1:0] next_cnt(input logic [TW-1:0] cur, input int unsigned c);
        logic [TW-1:0] dec;
        logic [TW-1:0] ld;
        dec = (cur != '0) ? cur - TW'(1) : '0;
        ld  = (c == 0) ? '0 : TW'(c - 1);
        return (dec > ld) ? dec : ld;
    endfunction

    // Legality depends only on request fields and registered counters.
    always_comb begin
        cmd      = 3'(req_cmd);
        rnk_i    = int'(req_rnk);
        bg_i     = int'(req_bg);
        bnk_i    = int'(req_bnk);
        in_range = (rnk_i < NUM_RNK) && (bg_i < NUM_BG) && (bnk_i < NUM_BNK);
        tgt_i    = rnk_i * BNK_PER_RNK + bg_i * NUM_BNK + bnk_i;
        sel_pre  = '0;
        sel_act  = '0;
        sel_rd   = '0;
        sel_wr   = '0;
        for (int e = 0; e < NUM_ENT; e++) begin
            if (e == tgt_i) begin
                sel_pre = cnt_q[e][CI_PRE];
                sel_act = cnt_q[e][CI_ACT];
                sel_rd  = cnt_q[e][CI_RD];
                sel_wr  = cnt_q[e][CI_WR];
            end
        end
        faw_ok = 1'b0;
        for (int r = 0; r < NUM_RNK; r++) begin
            if (r == rnk_i) faw_ok = faw_free[r];
        end
        case (cmd)
            CMD_PRE:         legal = (sel_pre == '0);
            CMD_ACT:         legal = (sel_act == '0) && faw_ok;
            CMD_RD, CMD_RDA: legal = (sel_rd == '0);
            CMD_WR, CMD_WRA: legal = (sel_wr == '0);
            CMD_PREA: begin
                legal = 1'b1;
                for (int e = 0; e < NUM_ENT; e++) begin
                    if ((e / BNK_PER_RNK == rnk_i) && (cnt_q[e][CI_PRE] != '0)) legal = 1'b0;
                end
            end
            default:         legal = 1'b0;
        endcase
        req_ready = (cmd == CMD_NOP) || (in_range && legal);
        accept    = req_valid && req_ready && !rst;
    end

    always_comb begin
        cons_t cons;
        logic  same_rnk, same_bg, same_bnk;
        for (int e = 0; e < NUM_ENT; e++) begin
            same_rnk = accept && (e / BNK_PER_RNK == rnk_i);
            same_bg  = same_rnk && ((e / NUM_BNK) % NUM_BG == bg_i);
            same_bnk = same_bg && (e % NUM_BNK == bnk_i);
            cons     = cmd_cons(cmd, same_bnk, same_bg, same_rnk);
            cnt_d[e][CI_PRE] = next_cnt(cnt_q[e][CI_PRE], cons.pre);
            cnt_d[e][CI_ACT] = next_cnt(cnt_q[e][CI_ACT], cons.act);
            cnt_d[e][CI_RD]  = next_cnt(cnt_q[e][CI_RD], cons.rd);
            cnt_d[e][CI_WR]  = next_cnt(cnt_q[e][CI_WR], cons.wr);
        end
        for (int r = 0; r < NUM_RNK; r++) begin
            act_fire[r] = accept && (cmd == CMD_ACT) && (rnk_i == r);
        end
        issue_valid_d = accept && (cmd != CMD_NOP);
        issue_cmd_d   = issue_valid_d ? req_cmd : issue_cmd_q;
        issue_rnk_d   = issue_valid_d ? req_rnk : issue_rnk_q;
        issue_bg_d    = issue_valid_d ? req_bg  : issue_bg_q;
        issue_bnk_d   = issue_valid_d ? req_bnk : issue_bnk_q;
    end

    for (genvar r = 0; r < NUM_RNK; r++) begin : g_faw
        act_window #(.TW(TW)) u_act_window (
            .clk       (clk),
            .rst       (rst),
            .act_fire  (act_fire[r]),
            .slot_free (faw_free[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENT; e++) begin
                for (int k = 0; k < NUM_CI; k++) cnt_q[e][k] <= '0;
            end
            issue_valid_q <= 1'b0;
            issue_cmd_q   <= '0;
            issue_rnk_q   <= '0;
            issue_bg_q    <= '0;
            issue_bnk_q   <= '0;
        end else begin
            cnt_q         <= cnt_d;
            issue_valid_q <= issue_valid_d;
            issue_cmd_q   <= issue_cmd_d;
            issue_rnk_q   <= issue_rnk_d;
            issue_bg_q    <= issue_bg_d;
            issue_bnk_q   <= issue_bnk_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_cmd   = issue_cmd_q;
    assign issue_rnk   = issue_rnk_q;
    assign issue_bg    = issue_bg_q;
    assign issue_bnk   = issue_bnk_q;

endmodule

// File: tb/tb_cmd_timing_gate.sv
// tb/tb_cmd_timing_gate.sv - scoreboard bench with absolute-time reference model
module tb_cmd_timing_gate;

    localparam logic [2:0] NOP = 3'd0, PRE = 3'd1, ACT = 3'd2, RD = 3'd3;
    localparam logic [2:0] WR = 3'd4, RDA = 3'd5, WRA = 3'd6, PREA = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_cmd = 3'd0;
    logic       req_rnk = 1'b0;
    logic [1:0] req_bg = 2'd0;
    logic [1:0] req_bnk = 2'd0;
    logic       req_ready;
    logic       issue_valid;
    logic [2:0] issue_cmd;
    logic       issue_rnk;
    logic [1:0] issue_bg;
    logic [1:0] issue_bnk;

    cmd_timing_gate dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_rnk     (req_rnk),
        .req_bg      (req_bg),
        .req_bnk     (req_bnk),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_cmd   (issue_cmd),
        .issue_rnk   (issue_rnk),
        .issue_bg    (issue_bg),
        .issue_bnk   (issue_bnk)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [2:0] cmd;
        logic       rnk;
        logic [1:0] bg;
        logic [1:0] bnk;
        int         at;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: earliest legal absolute cycle per bank and command class.
    int next_ok [16][4];
    int act_hist[$];

    function automatic void m_reset();
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 4; k++) next_ok[j][k] = 0;
        act_hist.delete();
    endfunction

    function automatic bit m_ready(input logic [2:0] c, input logic r, input logic [1:0] g,
                                   input logic [1:0] b, input int now);
        int idx;
        int n;
        if (c == NOP) return 1'b1;
        if (r != 1'b0) return 1'b0;
        idx = int'(g) * 4 + int'(b);
        case (c)
            PRE: return next_ok[idx][0] <= now;
            ACT: begin
                n = 0;
                foreach (act_hist[i]) if (now < act_hist[i] + 26) n++;
                return (next_ok[idx][1] <= now) && (n < 4);
            end
            RD, RDA: return next_ok[idx][2] <= now;
            WR, WRA: return next_ok[idx][3] <= now;
            default: begin
                for (int j = 0; j < 16; j++) if (next_ok[j][0] > now) return 1'b0;
                return 1'b1;
            end
        endcase
    endfunction

    function automatic void m_accept(input logic [2:0] c, input logic [1:0] g,
                                     input logic [1:0] b, input int now);
        int idx;
        int cn[4];
        bit sb, sg;
        idx = int'(g) * 4 + int'(b);
        for (int j = 0; j < 16; j++) begin
            sb = (j == idx);
            sg = (j / 4 == int'(g));
            for (int k = 0; k < 4; k++) cn[k] = 0;
            case (c)
                ACT: if (sb) begin cn[0] = 39; cn[1] = 55; cn[2] = 16; cn[3] = 16; end
                     else cn[1] = sg ? 6 : 4;
                PRE: if (sb) cn[1] = 16;
                PREA: cn[1] = 16;
                RD, RDA: begin
                    cn[2] = sg ? 6 : 4;
                    cn[3] = 8;
                    if (sb) cn[0] = 9;
                    if (sb && c == RDA) cn[1] = 9 + 16;
                end
                WR, WRA: begin
                    cn[3] = sg ? 6 : 4;
                    cn[2] = sg ? 23 : 17;
                    if (sb) cn[0] = 34;
                    if (sb && c == WRA) cn[1] = 34 + 16;
                end
                default: ;
            endcase
            for (int k = 0; k < 4; k++)
                if (now + cn[k] > next_ok[j][k]) next_ok[j][k] = now + cn[k];
        end
        if (c == ACT) act_hist.push_back(now);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
        end
    endtask

    // One request cycle; acc reports what the DUT accepted.
    task automatic step(input logic v, input logic [2:0] c, input logic r, input logic [1:0] g,
                        input logic [1:0] b, input logic rs, output logic acc);
        bit exp_rdy;
        @(negedge clk);
        req_valid = v;
        req_cmd   = c;
        req_rnk   = r;
        req_bg    = g;
        req_bnk   = b;
        rst       = rs;
        #1;
        exp_rdy = m_ready(c, r, g, b, cyc);
        acc = v && (req_ready === 1'b1) && !rs;
        if (!rs) begin
            total++;
            if (req_ready !== exp_rdy) begin
                bad++;
                $display("FAIL req_ready cyc=%0d cmd=%0d r=%0d g=%0d b=%0d got=%b exp=%b",
                         cyc, c, r, g, b, req_ready, exp_rdy);
            end
        end
        if (rs) m_reset();
        else if (v && exp_rdy && c != NOP) begin
            m_accept(c, g, b, cyc);
            sb_q.push_back('{cmd: c, rnk: r, bg: g, bnk: b, at: cyc + 1});
        end
    endtask

    task automatic hold(input logic [2:0] c, input logic [1:0] g, input logic [1:0] b,
                        input int base, output int rel);
        logic acc;
        rel = -1;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, c, 1'b0, g, b, 1'b0, acc);
            if (acc) begin
                rel = cyc - base;
                break;
            end
        end
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b0, NOP, 1'b0, 2'd0, 2'd0, 1'b1, acc);
        step(1'b0, NOP, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        chk("rst_issue_valid", int'(issue_valid), 0);
        chk("rst_issue_fields", int'({issue_cmd, issue_rnk, issue_bg, issue_bnk}), 0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (issue_valid === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected cyc=%0d got_cmd=%0d", cyc, issue_cmd);
            end else begin
                e = sb_q.pop_front();
                if (issue_cmd !== e.cmd || issue_rnk !== e.rnk || issue_bg !== e.bg ||
                    issue_bnk !== e.bnk || cyc != e.at) begin
                    bad++;
                    $display("FAIL issue_fields cyc=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d at=%0d",
                             cyc, issue_cmd, issue_rnk, issue_bg, issue_bnk,
                             e.cmd, e.rnk, e.bg, e.bnk, e.at);
                end
            end
        end else if (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
            total++;
            bad++;
            e = sb_q.pop_front();
            $display("FAIL issue_missing cyc=%0d got=0 exp_cmd=%0d", cyc, e.cmd);
        end
    end

    initial begin
        logic acc;
        int   base;
        int   rel;
        m_reset();

        // ACT then RD same bank: tRCD, with NOPs in between leaving state alone
        do_reset();
        step(1'b1, ACT, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        base = cyc;
        chk("act0_accept", int'(acc), 1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, NOP, 1'b0, 2'd0, 2'd0, 1'b0, acc);
            chk("nop_ready", int'(req_ready), 1);
        end
        hold(RD, 2'd0, 2'd0, base, rel);
        chk("rd_after_act_trcd", rel, 16);
        step(1'b0, NOP, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        chk("issue_pulse_valid", int'(issue_valid), 1);
        chk("issue_pulse_cmd", int'(issue_cmd), int'(RD));
        step(1'b0, NOP, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        chk("issue_pulse_end", int'(issue_valid), 0);
        chk("issue_cmd_hold", int'(issue_cmd), int'(RD));

        // tRRD_S and tRRD_L
        do_reset();
        step(1'b1, ACT, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        base = cyc;
        hold(ACT, 2'd1, 2'd0, base, rel);
        chk("act_other_bg_trrd_s", rel, 4);
        do_reset();
        step(1'b1, ACT, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        base = cyc;
        hold(ACT, 2'd0, 2'd1, base, rel);
        chk("act_same_bg_trrd_l", rel, 6);

        // Four-activate window
        do_reset();
        step(1'b1, ACT, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        base = cyc;
        hold(ACT, 2'd1, 2'd0, base, rel);
        chk("faw_act1", rel, 4);
        hold(ACT, 2'd2, 2'd0, base, rel);
        chk("faw_act2", rel, 8);
        hold(ACT, 2'd3, 2'd0, base, rel);
        chk("faw_act3", rel, 12);
        hold(ACT, 2'd0, 2'd1, base, rel);
        chk("faw_act4_tfaw", rel, 26);

        // Write-to-read turnaround
        do_reset();
        step(1'b1, WR, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        base = cyc;
        hold(RD, 2'd1, 2'd0, base, rel);
        chk("wr_rd_twtr_s", rel, 17);
        hold(RD, 2'd0, 2'd0, base, rel);
        chk("wr_rd_twtr_l", rel, 23);

        // Reset mid-countdown
        do_reset();
        step(1'b1, ACT, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        base = cyc;
        for (int i = 0; i < 4; i++) step(1'b0, NOP, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        step(1'b0, NOP, 1'b0, 2'd0, 2'd0, 1'b1, acc);
        step(1'b1, RD, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        chk("rd_after_midreset", int'(acc), 1);
        chk("rd_after_midreset_cyc", cyc - base, 6);

        // Out-of-range rank
        step(1'b1, ACT, 1'b1, 2'd0, 2'd0, 1'b0, acc);
        chk("oor_rank_ready", int'(req_ready), 0);

        // PREA waits for tRAS, then blocks ACT for tRP rank-wide
        do_reset();
        step(1'b1, ACT, 1'b0, 2'd2, 2'd3, 1'b0, acc);
        base = cyc;
        hold(PREA, 2'd0, 2'd0, base, rel);
        chk("prea_after_tras", rel, 39);
        hold(ACT, 2'd1, 2'd1, base, rel);
        chk("act_after_prea_trp", rel, 55);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) != 0), 3'($urandom_range(7)), ($urandom_range(15) == 0),
                 2'($urandom_range(3)), 2'($urandom_range(3)), ($urandom_range(299) == 0), acc);
        end
        for (int i = 0; i < 3; i++) step(1'b0, NOP, 1'b0, 2'd0, 2'd0, 1'b0, acc);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
